// File: rtl/systolic_result_drain.sv
// Read-side controller for the systolic PE array: runs one accumulation pass, subtracts the
// pre-run baseline and drains the results as a valid/ready stream. Option: SYSTOLIC_DRAIN_RELU_EN.
module systolic_result_drain #(
  parameter int DATAW = 16,
  parameter int ARRAY = 2,
  parameter int KW    = 8,
  localparam int NRES = ARRAY * ARRAY,
  localparam int IDXW = (NRES > 1) ? $clog2(NRES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [KW-1:0]         i_k_len,
  input  logic [NRES*DATAW-1:0] i_result_in,
  output logic                  o_systolic_en,
  output logic [DATAW-1:0]      o_res_data,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic                  o_res_last,
  output logic [IDXW-1:0]       o_res_idx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] BASE    = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NRES - 1);

  logic [2:0]       r_state;
  logic [DATAW-1:0] r_base  [NRES];
  logic [DATAW-1:0] r_final [NRES];
  logic [KW:0]      r_runCnt;
  logic [IDXW-1:0]  r_idx;
  logic             r_valid;
  logic             r_done;
  logic             r_sysEn;

  logic [DATAW-1:0] w_word [NRES];
  logic [KW:0]      w_runLoad;
  logic [DATAW-1:0] w_beat;
  logic             w_accept;

  // r00 sits at the MSBs of the bus, so element i is counted down from the top
  always_comb begin
    for (int i = 0; i < NRES; i++) begin
      w_word[i] = i_result_in[(NRES-1-i)*DATAW +: DATAW];
    end
  end

  // Counter runs RUN_LEN-1 down to 0; KW+1 bits so the largest k_len cannot overflow
  assign w_runLoad = {1'b0, i_k_len} + (KW+1)'(2*ARRAY - 2);
  assign w_accept  = r_valid && i_res_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_runCnt <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_sysEn  <= 1'b0;
      for (int i = 0; i < NRES; i++) begin
        r_base[i]  <= '0;
        r_final[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start && (i_k_len != '0)) r_state <= BASE;
        end
        BASE: begin
          for (int i = 0; i < NRES; i++) r_base[i] <= w_word[i];
          r_runCnt <= w_runLoad;
          r_sysEn  <= 1'b1;
          r_state  <= RUN;
        end
        RUN: begin
          if (r_runCnt == '0) begin
            r_sysEn <= 1'b0;
            r_state <= CAPTURE;
          end else begin
            r_runCnt <= r_runCnt - 1'b1;
          end
        end
        CAPTURE: begin
          for (int i = 0; i < NRES; i++) r_final[i] <= w_word[i] - r_base[i];
          r_idx   <= '0;
          r_valid <= 1'b1;
          r_state <= DRAIN;
        end
        DRAIN: begin
          // The done cycle stays in DRAIN so a start coinciding with done is ignored
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end else if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              r_valid <= 1'b0;
              r_idx   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SYSTOLIC_DRAIN_RELU_EN
  // Clamp only on the way out; r_final keeps the raw difference
  assign w_beat = r_final[r_idx][DATAW-1] ? '0 : r_final[r_idx];
`else
  assign w_beat = r_final[r_idx];
`endif

  assign o_systolic_en = r_sysEn;
  assign o_res_data    = r_valid ? w_beat : '0;
  assign o_res_valid   = r_valid;
  assign o_res_last    = r_valid && (r_idx == LAST_IDX);
  assign o_res_idx     = r_idx;
  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain; the bench plays the array and drives the result bus.
module tb_systolic_result_drain;

  localparam int DATAW = 16;
  localparam int ARRAY = 2;
  localparam int KW    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  kLen = '0;
  logic [63:0] resultIn = '0;
  logic        resReady = 1'b0;
  logic        sysEn;
  logic [15:0] resData;
  logic        resValid;
  logic        resLast;
  logic [1:0]  resIdx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int stepCount = 0;
  int firstValidEdge;
  int doneEdge;
  logic [15:0] gotData[$];
  int          gotIdx[$];
  logic        gotLast[$];

  systolic_result_drain #(.DATAW(DATAW), .ARRAY(ARRAY), .KW(KW)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_k_len(kLen), .i_result_in(resultIn),
    .o_systolic_en(sysEn), .o_res_data(resData), .o_res_valid(resValid),
    .i_res_ready(resReady), .o_res_last(resLast), .o_res_idx(resIdx),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    stepCount++;
  endtask

  // Pulse start, swap the bus to the final sums once the array is enabled, count enable cycles
  task automatic launch(input logic [7:0] k, input logic [63:0] baseBus, input logic [63:0] finalBus,
                        input int restartAt, output int enCycles);
    enCycles = 0;
    resultIn = baseBus;
    kLen = k;
    start = 1'b1;
    stepCount = 0;
    step();
    start = 1'b0;
    while (!sysEn && stepCount < 10) step();
    while (sysEn && enCycles < 400) begin
      resultIn = finalBus;
      start = (enCycles == restartAt);
      if (enCycles == restartAt) kLen = 8'd10;
      enCycles++;
      step();
    end
    start = 1'b0;
  endtask

  task automatic drainAll(output int hs);
    int guard;
    hs = 0;
    guard = 0;
    firstValidEdge = -1;
    doneEdge = -1;
    gotData.delete(); gotIdx.delete(); gotLast.delete();
    resReady = 1'b1;
    while (!done && guard < 60) begin
      if (resValid && firstValidEdge < 0) firstValidEdge = stepCount - 1;
      if (resValid && resReady) begin
        gotData.push_back(resData);
        gotIdx.push_back(int'(resIdx));
        gotLast.push_back(resLast);
        hs++;
      end
      guard++;
      step();
    end
    if (done) doneEdge = stepCount - 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({sysEn, resValid, resLast, resIdx, busy, done, resData} !== 23'd0)
      $display("[TB] FAIL reset_outputs: got %h required 0",
               {sysEn, resValid, resLast, resIdx, busy, done, resData});
    #3 rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_basic();
    int en, hs;
    logic [15:0] exp [4];
    exp[0] = 16'd5; exp[1] = 16'd6; exp[2] = 16'd7; exp[3] = 16'd8;
    launch(8'd4, 64'h0, {16'd5, 16'd6, 16'd7, 16'd8}, -1, en);
    checks++;
    if (en !== 7) begin errors++; $display("[TB] FAIL basic_en_cycles: got %0d required 7", en); end
    drainAll(hs);
    checks++;
    if (firstValidEdge !== 9) begin
      errors++; $display("[TB] FAIL basic_first_valid: got %0d required 9", firstValidEdge);
    end
    checks++;
    if (hs !== 4) begin errors++; $display("[TB] FAIL basic_handshakes: got %0d required 4", hs); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gotData[i] !== exp[i] || gotIdx[i] !== i || gotLast[i] !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL basic_beat%0d: got data %h idx %0d last %b required %h %0d %b",
                 i, gotData[i], gotIdx[i], gotLast[i], exp[i], i, (i == 3));
      end
    end
    checks++;
    if (doneEdge !== 13) begin errors++; $display("[TB] FAIL basic_done_edge: got %0d required 13", doneEdge); end
    // A start coinciding with done must not begin a new pass
    start = 1'b1;
    kLen = 8'd4;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_done_pulse: got done %b busy %b required 0 0", done, busy);
    end
  endtask

  task automatic test_wrap();
    int en, hs;
    logic [15:0] exp [4];
`ifdef SYSTOLIC_DRAIN_RELU_EN
    exp[0] = 16'h0000;
`else
    exp[0] = 16'hFFFF;
`endif
    exp[1] = 16'd1; exp[2] = 16'd2; exp[3] = 16'd3;
    launch(8'd2, {16'd1, 16'd1, 16'd1, 16'd1}, {16'd0, 16'd2, 16'd3, 16'd4}, -1, en);
    checks++;
    if (en !== 5) begin errors++; $display("[TB] FAIL wrap_en_cycles: got %0d required 5", en); end
    drainAll(hs);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gotData[i] !== exp[i]) begin
        errors++; $display("[TB] FAIL wrap_beat%0d: got %h required %h", i, gotData[i], exp[i]);
      end
    end
    step();
  endtask

  task automatic test_stall();
    int en, hs, guard, stallLeft;
    int badHold;
    logic [15:0] exp [4];
    exp[0] = 16'd5; exp[1] = 16'd6; exp[2] = 16'd7; exp[3] = 16'd8;
    launch(8'd1, 64'h0, {16'd5, 16'd6, 16'd7, 16'd8}, -1, en);
    gotData.delete();
    hs = 0; guard = 0; stallLeft = 5; badHold = 0;
    resReady = 1'b1;
    while (!done && guard < 60) begin
      if (resValid && resIdx == 2'd1 && stallLeft > 0) begin
        resReady = 1'b0;
        stallLeft--;
        checks++;
        if (resData !== 16'd6 || resIdx !== 2'd1 || resLast !== 1'b0) begin
          errors++; badHold++;
          $display("[TB] FAIL stall_hold: got data %h idx %0d last %b required 0006 1 0", resData, resIdx, resLast);
        end
      end else if (stallLeft == 0) begin
        resReady = (guard % 2 == 0);
      end
      if (resValid && resReady) begin
        gotData.push_back(resData);
        hs++;
      end
      guard++;
      step();
    end
    checks++;
    if (hs !== 4) begin errors++; $display("[TB] FAIL stall_handshakes: got %0d required 4", hs); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gotData[i] !== exp[i]) begin
        errors++; $display("[TB] FAIL stall_beat%0d: got %h required %h", i, gotData[i], exp[i]);
      end
    end
    resReady = 1'b1;
    step();
  endtask

  task automatic test_ignored_start();
    int en, hs;
    kLen = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || sysEn !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_k_start: got busy %b en %b required 0 0", busy, sysEn);
    end
    launch(8'd3, 64'h0, {16'd1, 16'd2, 16'd3, 16'd4}, 2, en);
    checks++;
    if (en !== 6) begin errors++; $display("[TB] FAIL restart_en_cycles: got %0d required 6", en); end
    drainAll(hs);
    checks++;
    if (hs !== 4) begin errors++; $display("[TB] FAIL restart_handshakes: got %0d required 4", hs); end
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_once: got busy %b required 0", busy); end
  endtask

  task automatic test_reset_mid_drain();
    int en, hs, guard;
    logic [15:0] exp [4];
    exp[0] = 16'd9; exp[1] = 16'd10; exp[2] = 16'd11; exp[3] = 16'd12;
    launch(8'd2, 64'h0, {16'd9, 16'd10, 16'd11, 16'd12}, -1, en);
    resReady = 1'b1;
    guard = 0;
    while (!(resValid && resIdx == 2'd2) && guard < 30) begin
      guard++;
      step();
    end
    checks++;
    if (!(resValid && resIdx == 2'd2)) begin
      errors++; $display("[TB] FAIL reach_beat2: got valid %b idx %0d required 1 2", resValid, resIdx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({sysEn, resValid, resLast, resIdx, busy, done, resData} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL midpass_reset: got %h required 0",
               {sysEn, resValid, resLast, resIdx, busy, done, resData});
    end
    #2 rst = 1'b1;
    step();
    launch(8'd1, {16'd1, 16'd1, 16'd1, 16'd1}, {16'd10, 16'd11, 16'd12, 16'd13}, -1, en);
    checks++;
    if (en !== 4) begin errors++; $display("[TB] FAIL post_reset_en: got %0d required 4", en); end
    drainAll(hs);
    checks++;
    if (hs !== 4) begin errors++; $display("[TB] FAIL post_reset_hs: got %0d required 4", hs); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gotData[i] !== exp[i] || gotIdx[i] !== i) begin
        errors++;
        $display("[TB] FAIL post_reset_beat%0d: got %h idx %0d required %h %0d", i, gotData[i], gotIdx[i], exp[i], i);
      end
    end
    step();
  endtask

  task automatic test_max_k();
    int en, hs;
    launch(8'd255, 64'h0, {16'd1, 16'd2, 16'd3, 16'd4}, -1, en);
    checks++;
    if (en !== 258) begin errors++; $display("[TB] FAIL maxk_en_cycles: got %0d required 258", en); end
    drainAll(hs);
    checks++;
    if (firstValidEdge !== 260) begin
      errors++; $display("[TB] FAIL maxk_first_valid: got %0d required 260", firstValidEdge);
    end
    checks++;
    if (hs !== 4) begin errors++; $display("[TB] FAIL maxk_handshakes: got %0d required 4", hs); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_ignored_start();
    test_reset_mid_drain();
    test_max_k();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
